// File: rtl/datapath_pkg.sv
// Shared datapath definitions: shifter state encoding and default geometry.
package datapath_pkg;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shr_state_e;

endpackage

// File: rtl/shift_right_seq_if.sv
// Start/done handshake bundle between the EX stage and the iterative right shifter.
interface shift_right_seq_if
    import datapath_pkg::*;
#(
    parameter int WIDTH   = datapath_pkg::WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
);

    logic               start;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;

    modport master (
        output start, in, shamt, arith,
        input  busy, done, out
    );

    modport slave (
        input  start, in, shamt, arith,
        output busy, done, out
    );

endinterface

// File: rtl/shift_right_seq_step.sv
// Combinational single-stage right shift by 0..STEP; vacated top bits take 'fill'.
module shift_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    // Shifting the complement in zeros and inverting back yields ones in the vacated bits.
    assign dout = fill ? ~((~din) >> k) : (din >> k);

endmodule

// File: rtl/shift_right_seq.sv
// Iterative logical/arithmetic right shifter, at most STEP bits per clock.
// Optional macro SHIFT_RIGHT_SRA_EN enables sign fill; otherwise arith is ignored.
module shift_right_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH   = datapath_pkg::WIDTH,
    parameter int STEP    = datapath_pkg::STEP,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    shift_right_seq_if.slave bus
);

    localparam int                 KW     = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_R = SHAMT_W'(STEP);

    shr_state_e         state, state_d;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;
    logic               fill;
    logic [KW-1:0]      k;
    logic               last;
    logic [WIDTH-1:0]   shifted;

    assign k    = (rem < STEP_R) ? KW'(rem) : KW'(STEP);
    assign last = (rem <= STEP_R);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .din  (acc),
        .k    (k),
        .fill (fill),
        .dout (shifted)
    );

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state;
        unique case (state)
            IDLE, DONE: state_d = bus.start ? SHIFT : IDLE;
            SHIFT:      if (last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values of the others.
        if (!rst) begin
            state   <= IDLE;
            acc     <= '0;
            rem     <= '0;
            bus.out <= '0;
        end else begin
            state <= state_d;
            if ((state == IDLE || state == DONE) && bus.start) begin
                acc <= bus.in;
                rem <= bus.shamt;
            end else if (state == SHIFT) begin
                acc <= shifted;
                rem <= rem - SHAMT_W'(k);
                if (last) bus.out <= shifted;
            end
        end
    end

`ifdef SHIFT_RIGHT_SRA_EN
    always_ff @(posedge clk) begin
        if (!rst)
            fill <= 1'b0;
        else if ((state == IDLE || state == DONE) && bus.start)
            fill <= bus.arith & bus.in[WIDTH-1];
    end
`else
    logic unused_arith;
    assign unused_arith = bus.arith;
    assign fill         = 1'b0;
`endif

    // Both flags decode the state register only, so neither sees an input combinationally.
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right shifter for the pipelined datapath's EX stage; the counterpart to the combinational left-shift used for branch-offset scaling. It performs logical or arithmetic right shifts by 0..WIDTH-1 with a start/done handshake, shifting at most STEP bits per clock. Typical uses are byte-address-to-word-index conversion (shift by 2) and the SRL/SRA instructions used by the SAD kernel. Because the shift is iterative, the shifter stays small, and the hazard unit stalls on `busy`.

## Interface
- WIDTH, 32, data width.
- STEP, 4, maximum bits shifted per cycle; a power of two that divides WIDTH.
- SHAMT_W, 5, shift-amount width, equal to clog2(WIDTH).
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous and active-low; sampled on the rising edge of Clk.
- start  input  1  request; sampled only in IDLE or DONE.
- in  input  WIDTH  operand, captured when start is accepted.
- shamt  input  SHAMT_W  shift amount, captured when start is accepted.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; `out` is valid from this cycle.
- out  output  WIDTH  result register; holds its value until the next completion.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE, with out=0, done=0, busy=0, and the internal accumulator and remaining count cleared.
- IDLE or DONE with start=1: load acc=in, rem=shamt and fill=arith&in[WIDTH-1], then go to SHIFT. Any other input in IDLE or DONE leaves the unit idle (DONE always goes to IDLE).
- SHIFT, each edge:
  - k = min(STEP, rem).
  - acc = acc >> k, with the top k bits set to fill.
  - rem = rem - k.
  - If the old rem <= STEP: out = the shifted acc, and go to DONE.
- DONE lasts one cycle, with done=1.
- shamt=0 still spends one SHIFT cycle (k=0), so out=in.
- rem is unsigned SHAMT_W bits and never underflows, since k <= rem.
- start while in SHIFT is ignored; there is no queueing, and the in-flight operation is not disturbed.
- Rst=0 during SHIFT aborts the operation: out returns to 0 and no done is produced.

## Timing
- start accepted at edge t, with n = max(1, ceil(shamt/STEP)):
  - busy=1 during cycles t+1 .. t+n.
  - out is updated and done=1 in the cycle after edge t+n.
- Worst case for WIDTH=32, STEP=4, shamt=31: n=8.
- Back-to-back: start asserted in the DONE cycle is accepted, giving no dead cycle between operations.
- done and busy are never high together.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Configuration
- SHIFT_RIGHT_SRA_EN:
  - Defined: arith selects sign fill as described above.
  - Undefined: fill is forced to 0, the arith input is ignored, and the sign-capture logic is removed. The port remains, to keep the interface stable.

## Structure
- Shared package `datapath_pkg` holds:
  - The state encoding typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10).
  - The default WIDTH and STEP constants.
- Sub-module `shift_step` is a combinational single-stage right shift by 0..STEP with fill input. It is instantiated once and holds no state.

## Test plan
- in=0x8000_0000, shamt=4, arith=0 -> done one edge after acceptance, out=0x0800_0000.
- in=0x8000_0000, shamt=4, arith=1:
  - With SHIFT_RIGHT_SRA_EN: out=0xF800_0000.
  - Without: out=0x0800_0000.
- in=0x0000_0400, shamt=2 -> out=0x0000_0100 (byte address to word index); in=0x1234_5678, shamt=0 -> out=0x1234_5678, n=1.
- in=0xFFFF_FFFF, shamt=31, arith=0 -> busy high for exactly 8 cycles, then done, out=0x0000_0001. A second start pulsed mid-operation is ignored and out is unchanged.
- Rst=0 at the 3rd SHIFT edge of a shamt=31 operation -> out=0, busy=0, done=0 on the next cycle with no done pulse. A subsequent start with in=0x10, shamt=4 gives out=0x1.
- Two operations started back-to-back, with start held through DONE -> the second completes after its own n cycles, and each done pulse lasts exactly one cycle.
